// File: rtl/bitstream_loader_if.sv
// Bitstream word stream: the source drives data/valid, the loader returns ready.
interface bitstream_loader_if #(
   parameter int unsigned WORD_W = 8
);
   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bitstream_loader.sv
// Feeds the configuration shift chain from a word stream, LSB first, then optionally
// recirculates the chain once and compares a CRC-16 of the returned bits.
module bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 4480,
   parameter int unsigned WORD_W    = 8,
   parameter bit          VERIFY_EN = 1'b1
) (
   input  logic               prog_clk,
   input  logic               prog_rst_n,
   input  logic               start,
   input  logic               abort,
   bitstream_loader_if.slave  s_if,
   output logic               prog_in,
   output logic               prog_en,
   input  logic               prog_out,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [15:0]        crc
);
   localparam int unsigned NUM_WORDS = CHAIN_LEN / WORD_W;
   localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int unsigned BIT_W     = $clog2(WORD_W + 1);
   localparam logic [15:0] CRC_POLY  = 16'h1021;
   localparam logic [15:0] CRC_INIT  = 16'hFFFF;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE} state_t;

   state_t              state, state_n;
   logic [WORD_W-1:0]   shreg, shreg_n;
   logic [BIT_W-1:0]    sh_bits, sh_bits_n;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
   logic [CNT_W-1:0]    word_cnt, word_cnt_n;
   logic [15:0]         crc_n, crc_rb, crc_rb_n;
   logic                err_n, s_ready_n, prog_en_n, busy_n, done_n;

   // One serial step of CRC-16-CCITT, MSB-first, unreflected.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? CRC_POLY : 16'h0000);
   endfunction

   // During readback the chain tail loops straight back to its head.
   assign prog_in = (state == ST_VERIFY) ? prog_out : shreg[0];

   // State and datapath registers.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         sh_bits     <= '0;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         crc         <= CRC_INIT;
         crc_rb      <= CRC_INIT;
         err         <= 1'b0;
         s_if.s_ready <= 1'b0;
         prog_en     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         shreg       <= shreg_n;
         sh_bits     <= sh_bits_n;
         bit_cnt     <= bit_cnt_n;
         word_cnt    <= word_cnt_n;
         crc         <= crc_n;
         crc_rb      <= crc_rb_n;
         err         <= err_n;
         s_if.s_ready <= s_ready_n;
         prog_en     <= prog_en_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

   // Next-state, datapath update and registered-output precomputation.
   always_comb begin
      state_n    = state;
      shreg_n    = shreg;
      sh_bits_n  = sh_bits;
      bit_cnt_n  = bit_cnt;
      word_cnt_n = word_cnt;
      crc_n      = crc;
      crc_rb_n   = crc_rb;
      err_n      = err;

      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (state == ST_DONE) state_n = ST_IDLE;
            if (start) begin
               state_n    = ST_LOAD;
               shreg_n    = '0;
               sh_bits_n  = '0;
               bit_cnt_n  = '0;
               word_cnt_n = '0;
               crc_n      = CRC_INIT;
               crc_rb_n   = CRC_INIT;
               err_n      = 1'b0;
            end
         end
         ST_LOAD: begin
            if (sh_bits != '0) begin
               shreg_n   = shreg >> 1;
               sh_bits_n = sh_bits - BIT_W'(1);
               bit_cnt_n = bit_cnt + CNT_W'(1);
               crc_n     = crc_step(crc, shreg[0]);
               if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
                  bit_cnt_n = '0;
                  state_n   = VERIFY_EN ? ST_VERIFY : ST_DONE;
               end
            end
            // A word landing on the last-bit cycle refills the register with no bubble.
            if (s_if.s_ready && s_if.s_valid) begin
               shreg_n    = s_if.s_data;
               sh_bits_n  = BIT_W'(WORD_W);
               word_cnt_n = word_cnt + CNT_W'(1);
            end
         end
         ST_VERIFY: begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
            crc_rb_n  = crc_step(crc_rb, prog_out);
            if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
               bit_cnt_n = '0;
               state_n   = ST_DONE;
               err_n     = (crc_rb_n != crc);
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (abort) begin
         state_n    = ST_IDLE;
         shreg_n    = '0;
         sh_bits_n  = '0;
         bit_cnt_n  = '0;
         word_cnt_n = '0;
      end

      s_ready_n = (state_n == ST_LOAD) && (word_cnt_n < CNT_W'(NUM_WORDS)) &&
                  (sh_bits_n <= BIT_W'(1));
      prog_en_n = ((state_n == ST_LOAD) && (sh_bits_n != '0)) || (state_n == ST_VERIFY);
      busy_n    = (state_n == ST_LOAD) || (state_n == ST_VERIFY);
      done_n    = (state_n == ST_DONE);
   end
endmodule

// File: tb/tb_bitstream_loader.sv
// Bench for bitstream_loader: chain models on two instances (readback on / off),
// table of load scenarios plus reset, abort and no-verify sequences.
module tb_bitstream_loader;
   localparam int unsigned N      = 256;
   localparam int unsigned W      = 8;
   localparam int unsigned NW     = N / W;
   localparam int          BUDGET = 20000;

   typedef struct {
      int duty;
      int pat;
      int inj_at;
      int start_at;
      int exp_err;
   } vec_t;

   logic prog_clk = 1'b0;
   logic prog_rst_n = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, abort = 1'b0, inj = 1'b0;
   logic pin_a, pen_a, pout_a, busy_a, done_a, err_a;
   logic pin_b, pen_b, pout_b, busy_b, done_b, err_b;
   logic [15:0] crc_a, crc_b;
   logic [N-1:0] chain_a, chain_b;
   logic [W-1:0] stream [NW];
   int n_chk = 0;
   int n_pass = 0;

   bitstream_loader_if #(.WORD_W(W)) ifa ();
   bitstream_loader_if #(.WORD_W(W)) ifb ();

   bitstream_loader #(.CHAIN_LEN(N), .WORD_W(W), .VERIFY_EN(1'b1)) dut_a (
      .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start_a), .abort(abort),
      .s_if(ifa), .prog_in(pin_a), .prog_en(pen_a), .prog_out(pout_a),
      .busy(busy_a), .done(done_a), .err(err_a), .crc(crc_a));

   bitstream_loader #(.CHAIN_LEN(N), .WORD_W(W), .VERIFY_EN(1'b0)) dut_b (
      .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start_b), .abort(abort),
      .s_if(ifb), .prog_in(pin_b), .prog_en(pen_b), .prog_out(pout_b),
      .busy(busy_b), .done(done_b), .err(err_b), .crc(crc_b));

   always #5 prog_clk = ~prog_clk;

   // Chain models: one shift toward the tail (bit 0) per enabled cycle.
   always @(posedge prog_clk) if (pen_a) chain_a <= {pin_a, chain_a[N-1:1]};
   always @(posedge prog_clk) if (pen_b) chain_b <= {pin_b, chain_b[N-1:1]};
   assign pout_a = chain_a[0] ^ inj;
   assign pout_b = chain_b[0];

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic chk_img(input string name, input logic [N-1:0] act);
      logic [N-1:0] exp;
      for (int w = 0; w < int'(NW); w++) exp[w*W +: W] = stream[w];
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [15:0] crc_model();
      logic [15:0] c = 16'hFFFF;
      logic fb;
      for (int w = 0; w < int'(NW); w++)
         for (int b = 0; b < int'(W); b++) begin
            fb = c[15] ^ stream[w][b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      return c;
   endfunction

   task automatic gen_stream(input int pat);
      for (int i = 0; i < int'(NW); i++)
         case (pat)
            0:       stream[i] = W'($urandom);
            1:       stream[i] = '0;
            2:       stream[i] = '1;
            3:       stream[i] = W'(i);
            default: stream[i] = 8'hA5;
         endcase
   endtask

   function automatic logic rd_en(input bit sel);    return sel ? pen_b  : pen_a;  endfunction
   function automatic logic rd_done(input bit sel);  return sel ? done_b : done_a; endfunction
   function automatic logic rd_err(input bit sel);   return sel ? err_b  : err_a;  endfunction
   function automatic logic rd_ready(input bit sel); return sel ? ifb.s_ready : ifa.s_ready; endfunction

   // Start a load and stream words; cycle 0 is the first negedge after start is sampled.
   task automatic run_load(input bit sel, input int duty, input int inj_at, input int start_at,
                           input int stop_at, output int en_cnt, output int done_cnt,
                           output int first_en, output int last_en, output int done_cyc,
                           output bit err_done, output bit timed_out);
      int idx = 0;
      bit pend = 1'b0;
      bit v;
      en_cnt = 0; done_cnt = 0; first_en = -1; last_en = -1; done_cyc = -1;
      err_done = 1'b0; timed_out = 1'b1;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(negedge prog_clk);
      start_a = 1'b0; start_b = 1'b0;
      chk(sel ? "b_err_cleared_by_start" : "a_err_cleared_by_start", rd_err(sel), 0);
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         if (rd_en(sel)) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
         end
         if (rd_done(sel)) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; err_done = rd_err(sel); end
         end
         if (stop_at >= 0 && en_cnt == stop_at) begin timed_out = 1'b0; break; end
         if (done_cyc >= 0 && cyc == done_cyc + 3) begin timed_out = 1'b0; break; end
         if (pend) idx++;
         v = (idx < int'(NW)) && (int'($urandom_range(99)) < duty);
         if (sel) begin
            ifb.s_valid = v;
            ifb.s_data  = (idx < int'(NW)) ? stream[idx] : '0;
         end else begin
            ifa.s_valid = v;
            ifa.s_data  = (idx < int'(NW)) ? stream[idx] : '0;
         end
         pend = v && rd_ready(sel);
         inj = (inj_at >= 0) && (en_cnt == inj_at);
         if (start_at >= 0 && en_cnt == start_at) begin
            if (sel) start_b = 1'b1; else start_a = 1'b1;
         end else begin
            start_a = 1'b0; start_b = 1'b0;
         end
         @(negedge prog_clk);
      end
      inj = 1'b0; start_a = 1'b0; start_b = 1'b0;
      ifa.s_valid = 1'b0; ifb.s_valid = 1'b0;
   endtask

   initial begin
      vec_t vecs [5];
      int en_cnt, done_cnt, first_en, last_en, done_cyc;
      bit err_done, to;

      vecs[0] = '{duty: 100, pat: 0, inj_at: -1,              start_at: -1, exp_err: 0};
      vecs[1] = '{duty: 30,  pat: 0, inj_at: -1,              start_at: -1, exp_err: 0};
      vecs[2] = '{duty: 100, pat: 3, inj_at: int'(N + N / 2), start_at: -1, exp_err: 1};
      vecs[3] = '{duty: 100, pat: 2, inj_at: -1,              start_at: -1, exp_err: 0};
      vecs[4] = '{duty: 100, pat: 4, inj_at: -1,              start_at: 40, exp_err: 0};

      ifa.s_valid = 1'b0; ifa.s_data = '0;
      ifb.s_valid = 1'b0; ifb.s_data = '0;
      repeat (3) @(negedge prog_clk);
      chk("rst_s_ready", ifa.s_ready, 0);
      chk("rst_prog_en", pen_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_err", err_a, 0);
      chk("rst_crc", crc_a, 16'hFFFF);
      prog_rst_n = 1'b1;
      @(negedge prog_clk);

      for (int i = 0; i < 5; i++) begin
         gen_stream(vecs[i].pat);
         run_load(1'b0, vecs[i].duty, vecs[i].inj_at, vecs[i].start_at, -1,
                  en_cnt, done_cnt, first_en, last_en, done_cyc, err_done, to);
         chk($sformatf("v%0d_timeout", i), to, 0);
         chk($sformatf("v%0d_en_cnt", i), en_cnt, 2 * N);
         chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
         chk($sformatf("v%0d_done_lag", i), done_cyc - last_en, 1);
         chk($sformatf("v%0d_err", i), err_done, vecs[i].exp_err);
         chk($sformatf("v%0d_crc", i), crc_a, crc_model());
         if (vecs[i].duty == 100) begin
            chk($sformatf("v%0d_first_en", i), first_en, 1);
            chk($sformatf("v%0d_span", i), last_en - first_en + 1, 2 * N);
         end
         if (vecs[i].inj_at < 0) chk_img($sformatf("v%0d_image", i), chain_a);
      end

      // Reset in the middle of LOAD.
      gen_stream(0);
      run_load(1'b0, 100, -1, -1, 100, en_cnt, done_cnt, first_en, last_en, done_cyc, err_done, to);
      chk("mid_rst_reach", to, 0);
      chk("mid_rst_busy_before", busy_a, 1);
      prog_rst_n = 1'b0;
      #1;
      chk("mid_rst_prog_en", pen_a, 0);
      chk("mid_rst_s_ready", ifa.s_ready, 0);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_done", done_a, 0);
      chk("mid_rst_crc", crc_a, 16'hFFFF);
      @(negedge prog_clk);
      prog_rst_n = 1'b1;
      @(negedge prog_clk);
      run_load(1'b0, 100, -1, -1, -1, en_cnt, done_cnt, first_en, last_en, done_cyc, err_done, to);
      chk("post_rst_en_cnt", en_cnt, 2 * N);
      chk("post_rst_done_cnt", done_cnt, 1);
      chk("post_rst_err", err_done, 0);
      chk("post_rst_crc", crc_a, crc_model());
      chk_img("post_rst_image", chain_a);

      // Abort during VERIFY.
      run_load(1'b0, 100, -1, -1, int'(N + 10), en_cnt, done_cnt, first_en, last_en, done_cyc, err_done, to);
      chk("abort_reach", to, 0);
      abort = 1'b1;
      @(negedge prog_clk);
      abort = 1'b0;
      chk("abort_busy", busy_a, 0);
      chk("abort_prog_en", pen_a, 0);
      chk("abort_s_ready", ifa.s_ready, 0);
      done_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (done_a) done_cnt++;
         @(negedge prog_clk);
      end
      chk("abort_no_done", done_cnt, 0);

      // All-zero stream, no readback pass.
      gen_stream(1);
      run_load(1'b1, 100, -1, -1, -1, en_cnt, done_cnt, first_en, last_en, done_cyc, err_done, to);
      chk("nv_timeout", to, 0);
      chk("nv_en_cnt", en_cnt, N);
      chk("nv_first_en", first_en, 1);
      chk("nv_span", last_en - first_en + 1, N);
      chk("nv_done_cnt", done_cnt, 1);
      chk("nv_done_lag", done_cyc - last_en, 1);
      chk("nv_err", err_done, 0);
      chk("nv_crc", crc_b, crc_model());
      chk_img("nv_image", chain_b);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
